// File: rtl/mul_pipe_pkg.sv
// Shared types for the fixed-latency multiplier pipe controller:
// per-stage tracking entry, controller FSM states and default depth.
package mul_pipe_pkg;

    localparam int unsigned LATENCY_DEFAULT = 5;

    // Widest destination tag an entry can carry; narrower tags are zero-extended.
    localparam int unsigned RD_W_MAX = 16;

    typedef logic [RD_W_MAX-1:0] rd_tag_t;

    typedef struct packed {
        logic    valid;
        rd_tag_t rd;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mul_pipe_ctrl.sv
// Control for a fixed-latency datapath: tracks {valid, rd} per stage,
// generates the stall/advance enable, issue handshake, writeback strobe,
// RAW hazard detection, occupancy count and a small IDLE/RUN/HOLD FSM.
// Optional: define MUL_PIPE_CTRL_PERF_EN to add the perf_stall_cycles
// counter output (cycles with pipe_enable low, saturating).
module mul_pipe_ctrl
    import mul_pipe_pkg::*;
#(
    parameter int unsigned LATENCY    = LATENCY_DEFAULT,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  logic [REG_ADDR_W-1:0]          issue_rd,
    output logic                           issue_ready,
    input  logic                           flush,
    input  logic                           wb_ready,
    output logic                           wb_valid,
    output logic [REG_ADDR_W-1:0]          wb_rd,
    output logic                           pipe_enable,
    input  logic [REG_ADDR_W-1:0]          query_rs1,
    input  logic [REG_ADDR_W-1:0]          query_rs2,
    output logic                           raw_hazard,
    output logic [$clog2(LATENCY+1)-1:0]   occupancy,
    output logic                           busy
`ifdef MUL_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cycles
`endif
);

    localparam int unsigned OCC_W = $clog2(LATENCY + 1);

    entry_t                entries [LATENCY];
    state_t                state;
    state_t                state_next;
    logic [OCC_W-1:0]      occ_next;
    logic                  accept;
    logic                  retire;
    rd_tag_t               q1;
    rd_tag_t               q2;

    // Handshake and stall: only a valid tail blocked by writeback stalls the pipe.
    assign pipe_enable = !(entries[LATENCY-1].valid && !wb_ready);
    assign issue_ready = pipe_enable && !flush;
    assign accept      = issue_valid && issue_ready;
    assign wb_valid    = entries[LATENCY-1].valid && !flush;
    assign wb_rd       = entries[LATENCY-1].rd[REG_ADDR_W-1:0];
    assign retire      = wb_valid && wb_ready;
    assign q1          = rd_tag_t'(query_rs1);
    assign q2          = rd_tag_t'(query_rs2);

    // Stage entry shift register; flush kills valid bits, reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pipe_enable) begin
                entries[0].valid <= accept;
                entries[0].rd    <= rd_tag_t'(issue_rd);
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    entries[i] <= entries[i-1];
                end
            end
            if (flush) begin
                for (int unsigned i = 0; i < LATENCY; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end
        end
    end

    // RAW hazard: any valid in-flight non-zero destination matching a source tag.
    always_comb begin
        raw_hazard = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            if (entries[i].valid && (entries[i].rd != '0) &&
                ((entries[i].rd == q1) || (entries[i].rd == q2))) begin
                raw_hazard = 1'b1;
            end
        end
    end

    // Next occupancy: flush wins, accept and retire together cancel out.
    always_comb begin
        occ_next = occupancy;
        if (flush) begin
            occ_next = '0;
        end else if (accept && !retire) begin
            occ_next = occupancy + OCC_W'(1);
        end else if (retire && !accept) begin
            occ_next = occupancy - OCC_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    // FSM next-state decode; flush returns to IDLE from any state.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_next = RUN;
                RUN: begin
                    if (occ_next == '0) begin
                        state_next = IDLE;
                    end else if (wb_valid && !wb_ready) begin
                        state_next = HOLD;
                    end
                end
                HOLD: if (wb_ready) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

`ifdef MUL_PIPE_CTRL_PERF_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (!pipe_enable && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl (LATENCY=5): scoreboard queue of
// in-flight ops with due cycles, compared against writeback each cycle.
module tb_mul_pipe_ctrl;

    localparam int LAT = 5;
    localparam int RW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [RW-1:0] issue_rd;
    logic          issue_ready;
    logic          flush;
    logic          wb_ready;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic          pipe_enable;
    logic [RW-1:0] query_rs1;
    logic [RW-1:0] query_rs2;
    logic          raw_hazard;
    logic [2:0]    occupancy;
    logic          busy;
`ifdef MUL_PIPE_CTRL_PERF_EN
    logic [31:0]   perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    mul_pipe_ctrl #(.LATENCY(LAT), .REG_ADDR_W(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .flush       (flush),
        .wb_ready    (wb_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .pipe_enable (pipe_enable),
        .query_rs1   (query_rs1),
        .query_rs2   (query_rs2),
        .raw_hazard  (raw_hazard),
        .occupancy   (occupancy),
        .busy        (busy)
`ifdef MUL_PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    typedef struct {
        logic [RW-1:0] rd;
        int            due;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: drive inputs, check all outputs against the scoreboard, update it.
    task automatic step(input logic iv, input logic [RW-1:0] rd, input logic fl,
                        input logic wr, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        logic tail, exp_pe, exp_ir, exp_wv, exp_hz;
        sb_t  e;
        @(negedge clk);
        issue_valid = iv;
        issue_rd    = rd;
        flush       = fl;
        wb_ready    = wr;
        query_rs1   = r1;
        query_rs2   = r2;
        #1;
        tail   = (sb.size() > 0) && (sb[0].due == cyc);
        exp_pe = !(tail && !wr);
        exp_ir = exp_pe && !fl;
        exp_wv = tail && !fl;
        exp_hz = 1'b0;
        foreach (sb[i]) begin
            if ((sb[i].rd != '0) && ((sb[i].rd == r1) || (sb[i].rd == r2))) exp_hz = 1'b1;
        end
        check_eq("wb_valid",    32'(wb_valid),    32'(exp_wv));
        check_eq("pipe_enable", 32'(pipe_enable), 32'(exp_pe));
        check_eq("issue_ready", 32'(issue_ready), 32'(exp_ir));
        check_eq("occupancy",   32'(occupancy),   32'(sb.size()));
        check_eq("raw_hazard",  32'(raw_hazard),  32'(exp_hz));
        if (exp_wv) check_eq("wb_rd", 32'(wb_rd), 32'(sb[0].rd));
        if (fl) begin
            sb.delete();
        end else if (!exp_pe) begin
            foreach (sb[i]) sb[i].due = sb[i].due + 1;
        end else begin
            if (exp_wv && wr) void'(sb.pop_front());
            if (iv && exp_ir) begin
                e.rd  = rd;
                e.due = cyc + LAT;
                sb.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, '0, '0);
    endtask

    // Reset held for one edge, with flush also high to exercise priority.
    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        flush       = 1'b1;
        issue_valid = 1'b0;
        wb_ready    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        sb.delete();
        cyc++;
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
        wb_ready    = 1'b1;
        query_rs1   = '0;
        query_rs2   = '0;
        do_reset();

        // Reset state
        idle(1);
        check_eq("busy_reset", 32'(busy), 32'd0);

        // Single op rd=7
        step(1'b1, 5'd7, 1'b0, 1'b1, '0, '0);
        idle(1);
        check_eq("busy_single_run", 32'(busy), 32'd1);
        idle(6);
        check_eq("busy_single_done", 32'(busy), 32'd0);

        // Back-to-back rd=1..5, then accept+retire at full occupancy
        for (int k = 1; k <= 5; k++) step(1'b1, 5'(k), 1'b0, 1'b1, '0, '0);
        for (int k = 6; k <= 8; k++) step(1'b1, 5'(k), 1'b0, 1'b1, '0, '0);
        check_eq("busy_full", 32'(busy), 32'd1);

        // Backpressure: tail valid, wb_ready low for 3 cycles, issue attempts refused
        for (int k = 0; k < 3; k++) step(1'b1, 5'd20, 1'b0, 1'b0, '0, '0);
        check_eq("busy_hold", 32'(busy), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, '0, '0);
`ifdef MUL_PIPE_CTRL_PERF_EN
        check_eq("perf_stall", perf_stall_cycles, 32'd3);
`endif
        idle(10);
        check_eq("busy_drained", 32'(busy), 32'd0);

        // Hazard: rd=9 at stage 2 vs query_rs1=9; rd=0 never hazards
        step(1'b1, 5'd9, 1'b0, 1'b1, 5'd9, '0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b1, 5'd9, '0);
        check_eq("hazard_stage2", 32'(raw_hazard), 32'd1);
        idle(4);
        step(1'b1, 5'd0, 1'b0, 1'b1, '0, '0);
        step(1'b0, '0, 1'b0, 1'b1, '0, '0);
        check_eq("hazard_rd0", 32'(raw_hazard), 32'd0);
        idle(6);

        // Flush with issue at occupancy 3
        for (int k = 11; k <= 13; k++) step(1'b1, 5'(k), 1'b0, 1'b1, '0, '0);
        step(1'b1, 5'd14, 1'b1, 1'b1, '0, '0);
        idle(1);
        check_eq("busy_flush", 32'(busy), 32'd0);
        idle(7);

        // Reset mid-stream
        for (int k = 21; k <= 23; k++) step(1'b1, 5'(k), 1'b0, 1'b1, 5'd22, '0);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1, 5'd22, '0);
        check_eq("busy_midreset", 32'(busy), 32'd0);
        idle(7);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(12);
        check_eq("busy_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
